// File: rtl/fir_pkg.sv
// fir_pkg: shared types and default sizing for the fir driver slice.
//   state_e    - driver FSM states
//   TAPSHALF   - coefficients actually loaded (symmetric filter)
//   CFG_W      - serialised coefficient stream length in bits
//   CNT_W      - width of a counter that can hold 0..CFG_W
//   cnt_width  - helper returning the counter width for an arbitrary bit count
package fir_pkg;

    localparam int unsigned BITS_DEFAULT = 8;
    localparam int unsigned TAPS_DEFAULT = 6;
    localparam int unsigned TAPSHALF     = TAPS_DEFAULT / 2;
    localparam int unsigned CFG_W        = TAPSHALF * BITS_DEFAULT;
    localparam int unsigned CNT_W        = $clog2(CFG_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        START,
        WAIT,
        OUT
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fir_coeff_ser.sv
// fir_coeff_ser: parallel-to-serial shifter for the coefficient stream.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_load       - capture i_data and start shifting SER_W bits
//   i_data       - parallel word, sent MSB first
//   o_bit        - current serial bit (valid while o_busy)
//   o_busy       - bits remain to be sent
//   o_last       - the bit on o_bit is the final one
module fir_coeff_ser
    import fir_pkg::*;
#(
    parameter int unsigned SER_W  = CFG_W,
    parameter int unsigned SER_CW = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [SER_W-1:0] i_data,
    output logic             o_bit,
    output logic             o_busy,
    output logic             o_last
);

    logic [SER_W-1:0]  r_shift;
    logic [SER_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= SER_CW'(SER_W);
        end else if (r_cnt != '0) begin
            r_shift <= {r_shift[SER_W-2:0], 1'b0};
            r_cnt   <= r_cnt - SER_CW'(1);
        end
    end

    assign o_bit  = r_shift[SER_W-1];
    assign o_busy = (r_cnt != '0);
    assign o_last = (r_cnt == SER_CW'(1));

endmodule

// File: rtl/fir_driver.sv
// fir_driver: initiator-side controller for the fir core.
// Loads a parallel coefficient set into fir serially, then streams single samples
// (one-cycle start, wait for done) and returns y on a valid/ready output.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        - coefficient set handshake, cfg_coeffs = {coeff[n-1]..coeff[0]}
//   in_valid/in_ready/in_data  - sample handshake
//   out_valid/out_ready/out_data - result handshake (captured y)
//   coeff_load_out, coeff_out, lock_out, start, x - to fir
//   done, y                    - from fir
//   err                        - sticky timeout flag
// Optional: define FIR_DRIVER_TIMEOUT_EN to enable the done timeout (TIMEOUT cycles);
// otherwise err is tied 0 and WAIT waits indefinitely.
module fir_driver
    import fir_pkg::*;
#(
    parameter int unsigned BITS    = BITS_DEFAULT,
    parameter int unsigned TAPS    = TAPS_DEFAULT,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [(TAPS/2)*BITS-1:0]   cfg_coeffs,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BITS-1:0]            out_data,
    output logic                       coeff_load_out,
    output logic                       coeff_out,
    output logic                       lock_out,
    output logic                       start,
    output logic [BITS-1:0]            x,
    input  logic                       done,
    input  logic [BITS-1:0]            y,
    output logic                       err
);

    localparam int unsigned SER_W  = (TAPS / 2) * BITS;
    localparam int unsigned SER_CW = cnt_width(SER_W);

    state_e          r_state, w_state_nxt;
    logic            r_lock, w_lock_nxt;
    logic [BITS-1:0] r_x, w_x_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [BITS-1:0] r_out_data, w_out_data_nxt;
    logic            w_ser_load, w_ser_bit, w_ser_busy, w_ser_last;
    logic            w_cfg_rdy;

`ifdef FIR_DRIVER_TIMEOUT_EN
    localparam int unsigned TMO_W = cnt_width(TIMEOUT);
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             r_err, w_err_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    fir_coeff_ser #(
        .SER_W  (SER_W),
        .SER_CW (SER_CW)
    ) u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_ser_load),
        .i_data (cfg_coeffs),
        .o_bit  (w_ser_bit),
        .o_busy (w_ser_busy),
        .o_last (w_ser_last)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_lock_nxt      = r_lock;
        w_x_nxt         = r_x;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_ser_load      = 1'b0;
        w_cfg_rdy       = 1'b0;
        in_ready        = 1'b0;
`ifdef FIR_DRIVER_TIMEOUT_EN
        w_tmo_nxt       = r_tmo;
        w_err_nxt       = r_err;
`endif
        unique case (r_state)
            IDLE: begin
                w_cfg_rdy = 1'b1;
                if (cfg_valid) begin
                    w_ser_load  = 1'b1;
                    w_lock_nxt  = 1'b0;
                    w_state_nxt = LOAD;
`ifdef FIR_DRIVER_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (w_ser_last) begin
                    w_lock_nxt  = 1'b1;
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_cfg_rdy = 1'b1;
                // A reload takes priority over a sample offered in the same cycle.
                if (cfg_valid) begin
                    w_ser_load  = 1'b1;
                    w_lock_nxt  = 1'b0;
                    w_state_nxt = LOAD;
`ifdef FIR_DRIVER_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_x_nxt     = in_data;
                        w_state_nxt = START;
                    end
                end
            end
            START: begin
`ifdef FIR_DRIVER_TIMEOUT_EN
                w_tmo_nxt   = '0;
`endif
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (done) begin
                    w_out_data_nxt  = y;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = OUT;
`ifdef FIR_DRIVER_TIMEOUT_EN
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_err_nxt       = 1'b1;
                    w_out_data_nxt  = '0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = OUT;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
`endif
                end
            end
            OUT: begin
                if (r_out_valid && out_ready) begin
                    w_out_valid_nxt = 1'b0;
                end
                // Leave only once done has dropped so a stale done is never reused.
                if ((!r_out_valid || out_ready) && !done) begin
                    w_state_nxt = READY;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lock      <= 1'b0;
            r_x         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock      <= w_lock_nxt;
            r_x         <= w_x_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

`ifdef FIR_DRIVER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= w_tmo_nxt;
            r_err <= w_err_nxt;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Gated by reset so every output reads 0 while rst_n is low.
    assign cfg_ready      = w_cfg_rdy & rst_n;
    assign coeff_load_out = (r_state == LOAD) & w_ser_busy;
    assign coeff_out      = coeff_load_out & w_ser_bit;
    assign lock_out       = r_lock;
    assign start          = (r_state == START);
    assign x              = r_x;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;

endmodule

// File: tb/tb_fir_driver.sv
module tb_fir_driver;

    localparam int unsigned BITS    = 8;
    localparam int unsigned TAPS    = 6;
    localparam int unsigned CFG_W   = (TAPS / 2) * BITS;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_coeffs = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BITS-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BITS-1:0]  out_data;
    logic             coeff_load_out;
    logic             coeff_out;
    logic             lock_out;
    logic             start;
    logic [BITS-1:0]  x;
    logic             done = 1'b0;
    logic [BITS-1:0]  y = '0;
    logic             err;

    fir_driver #(
        .BITS    (BITS),
        .TAPS    (TAPS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_coeffs     (cfg_coeffs),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .coeff_load_out (coeff_load_out),
        .coeff_out      (coeff_out),
        .lock_out       (lock_out),
        .start          (start),
        .x              (x),
        .done           (done),
        .y              (y),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [BITS-1:0] din;
        logic [BITS-1:0] yv;
        int              done_dly;
        int              bp_cycles;
        int              stale_cycles;
        logic [BITS-1:0] exp_out;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] all_outs();
        return {cfg_ready, in_ready, out_valid, coeff_load_out, coeff_out, lock_out, start, err,
                x, out_data};
    endfunction

    // Offer a coefficient set and capture the serial stream until coeff_load_out falls.
    task automatic load_coeffs(input logic [CFG_W-1:0] c, input string tag);
        logic [CFG_W-1:0] cap;
        int               n;
        bit               bad;
        cap = '0;
        n   = 0;
        bad = 1'b0;
        cfg_coeffs = c;
        cfg_valid  = 1'b1;
        #1;
        check({tag, " cfg_ready"}, cfg_ready, 1);
        check({tag, " in_ready with cfg"}, in_ready, 0);
        tick();
        cfg_valid = 1'b0;
        check({tag, " lock dropped"}, lock_out, 0);
        while (coeff_load_out === 1'b1 && n < 40) begin
            cap = {cap[CFG_W-2:0], coeff_out};
            if (cfg_ready !== 1'b0 || in_ready !== 1'b0 || start !== 1'b0) bad = 1'b1;
            n++;
            tick();
        end
        check({tag, " load cycles"}, n, CFG_W);
        check({tag, " serial stream"}, cap, c);
        check({tag, " quiet during load"}, bad, 0);
        check({tag, " lock after load"}, lock_out, 1);
        check({tag, " load_out low"}, coeff_load_out, 0);
    endtask

    // One sample through the driver, with the bench acting as the fir responder.
    task automatic do_sample(input vec_t v, input string tag);
        int n_start;
        bit x_bad;
        bit bp_bad;
        bit stale_bad;
        n_start   = 0;
        x_bad     = 1'b0;
        bp_bad    = 1'b0;
        stale_bad = 1'b0;
        in_data  = v.din;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, " start pulse"}, start, 1);
        check({tag, " x"}, x, v.din);
        tick();
        for (int d = 0; d < v.done_dly; d++) begin
            if (start !== 1'b0) n_start++;
            if (x !== v.din) x_bad = 1'b1;
            tick();
        end
        if (start !== 1'b0) n_start++;
        if (x !== v.din) x_bad = 1'b1;
        done = 1'b1;
        y    = v.yv;
        tick();
        y = ~v.yv;
        check({tag, " x stable"}, x_bad, 0);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " out_data"}, out_data, v.exp_out);
        for (int b = 0; b < v.bp_cycles; b++) begin
            if (out_valid !== 1'b1 || out_data !== v.exp_out || in_ready !== 1'b0) bp_bad = 1'b1;
            if (start !== 1'b0) n_start++;
            tick();
        end
        check({tag, " backpressure hold"}, bp_bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, out_valid, 0);
        for (int s = 0; s < v.stale_cycles; s++) begin
            if (in_ready !== 1'b0 || start !== 1'b0) stale_bad = 1'b1;
            tick();
        end
        if (in_ready !== 1'b0) stale_bad = 1'b1;
        check({tag, " held while done stale"}, stale_bad, 0);
        done = 1'b0;
        tick();
        check({tag, " back to ready"}, in_ready, 1);
        check({tag, " single start"}, n_start, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{din: 8'h24, yv: 8'h64, done_dly: 3, bp_cycles: 10, stale_cycles: 2,
                    exp_out: 8'h64};
        vecs[1] = '{din: 8'h80, yv: 8'h80, done_dly: 0, bp_cycles: 0, stale_cycles: 0,
                    exp_out: 8'h80};
        vecs[2] = '{din: 8'hFF, yv: 8'hA5, done_dly: 5, bp_cycles: 2, stale_cycles: 3,
                    exp_out: 8'hA5};

        // Reset state
        #2;
        rst_n = 1'b0;
        #1;
        check("reset outputs", all_outs(), 24'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("idle cfg_ready", cfg_ready, 1);
        check("idle in_ready", in_ready, 0);
        check("idle lock", lock_out, 0);

        // Coefficient serialisation 0x332211
        load_coeffs(24'h332211, "load1");

        // Table-driven samples
        for (int i = 0; i < 3; i++) begin
            do_sample(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous cfg and sample in READY: reload wins
        in_data  = 8'h42;
        in_valid = 1'b1;
        load_coeffs(24'h0A0B0C, "reload");
        do_sample('{din: 8'h42, yv: 8'h17, done_dly: 1, bp_cycles: 1, stale_cycles: 0,
                    exp_out: 8'h17}, "after_reload");

        // Timeout behaviour with done held low
        in_data  = 8'h5A;
        in_valid = 1'b1;
        y        = 8'hEE;
        tick();
        in_valid = 1'b0;
        tick();
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
`ifdef FIR_DRIVER_TIMEOUT_EN
        check("timeout cycles", n, TIMEOUT);
        check("timeout err", err, 1);
        check("timeout out_valid", out_valid, 1);
        check("timeout out_data", out_data, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("timeout drained", out_valid, 0);
        check("timeout ready", in_ready, 1);
        check("err sticky", err, 1);
        load_coeffs(24'h332211, "load_clr");
        check("err cleared by cfg", err, 0);
`else
        check("no timeout wait", n, 100);
        check("no timeout err", err, 0);
        check("no timeout out_valid", out_valid, 0);
        done = 1'b1;
        y    = 8'h3C;
        tick();
        check("late done out_valid", out_valid, 1);
        check("late done out_data", out_data, 8'h3C);
        out_ready = 1'b1;
        done      = 1'b0;
        tick();
        out_ready = 1'b0;
        check("late done ready", in_ready, 1);
        check("late done err", err, 0);
`endif

        // Reset in the middle of a load, at bit 10
        cfg_coeffs = 24'h332211;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int b = 0; b < 10; b++) tick();
        check("midload precondition", coeff_load_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midload reset outputs", all_outs(), 24'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post reset cfg_ready", cfg_ready, 1);
        check("post reset in_ready", in_ready, 0);
        check("post reset load_out", coeff_load_out, 0);
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("no sample before load", start, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
